// File: rtl/vend_pkg.sv
// vend_pkg: coin encodings, coin values, FSM states and coin value lookup for the vending controller
package vend_pkg;
  localparam logic [1:0] COIN_5 = 2'd0, COIN_10 = 2'd1, COIN_25 = 2'd2, COIN_BAD = 2'd3;
  localparam int VAL_5 = 5, VAL_10 = 10, VAL_25 = 25;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  function automatic logic [7:0] coin_value(input logic [1:0] t);
    return t == COIN_5 ? 8'(VAL_5) : t == COIN_10 ? 8'(VAL_10) : t == COIN_25 ? 8'(VAL_25) : 8'd0;
  endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: coin/keypad strobes in, credit/dispense/change actuator outputs; master drives strobes, slave is the controller
interface vend_if #(parameter int CREDIT_W = 8);
  logic coin_valid;
  logic [1:0] coin_type;
  logic sel_valid;
  logic [1:0] sel_item;
  logic cancel;
  logic [CREDIT_W-1:0] credit;
  logic coin_reject;
  logic sel_denied;
  logic dispense;
  logic [1:0] dispense_item;
  logic change_valid;
  logic [1:0] change_coin;
  logic busy;
  modport master(
    output coin_valid, coin_type, sel_valid, sel_item, cancel,
    input credit, coin_reject, sel_denied, dispense, dispense_item, change_valid, change_coin, busy
  );
  modport slave(
    input coin_valid, coin_type, sel_valid, sel_item, cancel,
    output credit, coin_reject, sel_denied, dispense, dispense_item, change_valid, change_coin, busy
  );
endinterface

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy change picker; credit in, largest coin type <= credit and its value out
module vend_change_sel import vend_pkg::*; #(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value
);
  assign coin = credit >= CREDIT_W'(VAL_25) ? COIN_25 : credit >= CREDIT_W'(VAL_10) ? COIN_10 : COIN_5;
  assign value = CREDIT_W'(coin_value(coin));
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending sequencer; clk, rst_n (async low), bus = coin/select/cancel strobes in, registered credit/pulse/change outputs
module vend_ctrl import vend_pkg::*; #(
  parameter int PRICE0     = 25,
  parameter int PRICE1     = 35,
  parameter int PRICE2     = 50,
  parameter int PRICE3     = 65,
  parameter int MAX_CREDIT = 100,
  parameter int CREDIT_W   = 8
) (
  input logic clk,
  input logic rst_n,
  vend_if.slave bus
);
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, price, sum, chg_val;
  logic [1:0] chg_coin, item, item_n, coin, coin_n;
  logic rej, rej_n, den, den_n, disp, disp_n, chg, chg_n, busy, busy_n, give;
  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_sel (.credit(credit), .coin(chg_coin), .value(chg_val));
  assign price = CREDIT_W'(bus.sel_item == 2'd0 ? PRICE0 : bus.sel_item == 2'd1 ? PRICE1 :
                           bus.sel_item == 2'd2 ? PRICE2 : PRICE3);
  assign sum = credit + CREDIT_W'(coin_value(bus.coin_type));
  always_comb begin
    state_n = state;
    credit_n = credit;
    rej_n = 1'b0;
    den_n = 1'b0;
    disp_n = 1'b0;
    item_n = 2'd0;
    chg_n = 1'b0;
    coin_n = 2'd0;
    give = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (bus.cancel && state == CREDIT) begin
          give = 1'b1;
          rej_n = bus.coin_valid;
        end else if (bus.sel_valid) begin
          rej_n = bus.coin_valid;
          if (credit >= price) begin
            state_n = VEND;
            disp_n = 1'b1;
            item_n = bus.sel_item;
            credit_n = credit - price;
          end else den_n = 1'b1;
        end else if (bus.coin_valid) begin
          if (bus.coin_type == COIN_BAD || sum > CREDIT_W'(MAX_CREDIT)) rej_n = 1'b1;
          else begin
            credit_n = sum;
            state_n = CREDIT;
          end
        end
      end
      default: begin
        rej_n = bus.coin_valid;
        give = credit != '0;
        state_n = IDLE;
      end
    endcase
    // Payout starts on the entry edge so change_valid lines up with the first CHANGE cycle
    if (give) begin
      state_n = CHANGE;
      chg_n = 1'b1;
      coin_n = chg_coin;
      credit_n = credit - chg_val;
    end
  end
  assign busy_n = state_n == VEND || state_n == CHANGE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      credit <= '0;
      rej <= 1'b0;
      den <= 1'b0;
      disp <= 1'b0;
      item <= 2'd0;
      chg <= 1'b0;
      coin <= 2'd0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      rej <= rej_n;
      den <= den_n;
      disp <= disp_n;
      item <= item_n;
      chg <= chg_n;
      coin <= coin_n;
      busy <= busy_n;
    end
  assign bus.credit = credit;
  assign bus.coin_reject = rej;
  assign bus.sel_denied = den;
  assign bus.dispense = disp;
  assign bus.dispense_item = item;
  assign bus.change_valid = chg;
  assign bus.change_coin = coin;
  assign bus.busy = busy;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed and random checks of vend_ctrl against a credit/payout-plan reference model
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vend_if #(.CREDIT_W(8)) vif();
  vend_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(vif));
  // stimulus word: {coin_valid, coin_type[1:0], sel_valid, sel_item[1:0], cancel}
  localparam logic [6:0] NOP = 7'b0000000, CAN = 7'b0000001;
  localparam logic [6:0] C5 = 7'b1000000, C10 = 7'b1010000, C25 = 7'b1100000, CBAD = 7'b1110000;
  function automatic logic [6:0] sel(input logic [1:0] i);
    return {3'b000, 1'b1, i, 1'b0};
  endfunction
  int n_chk = 0, n_fail = 0;
  int price[4] = '{25, 35, 50, 65};
  int mc = 0;
  int q[$];
  bit in_vend = 0;
  logic [16:0] exp, obs;
  // {credit, coin_reject, sel_denied, dispense, item, change_valid, change_coin, busy}; item/coin only meaningful with their strobe
  assign obs = {vif.credit, vif.coin_reject, vif.sel_denied, vif.dispense,
                vif.dispense ? vif.dispense_item : 2'd0, vif.change_valid,
                vif.change_valid ? vif.change_coin : 2'd0, vif.busy};
  task automatic model_reset;
    mc = 0;
    q.delete();
    in_vend = 0;
  endtask
  // Drive one cycle of stimulus, predict the outputs after the edge, sample 1 ns past the edge
  task automatic cyc(input logic [6:0] s);
    bit cvi = s[6], svi = s[3], cn = s[0];
    logic [1:0] ct = s[5:4], si = s[2:1];
    bit rej = 0, den = 0, disp = 0, chg = 0, start = 0, busy;
    logic [1:0] item = 0, cc = 0;
    int v, c;
    {vif.coin_valid, vif.coin_type, vif.sel_valid, vif.sel_item, vif.cancel} = s;
    if (in_vend || q.size() > 0) begin
      rej = cvi;
      if (in_vend) begin
        in_vend = 0;
        start = mc > 0;
      end
    end else if (cn && mc > 0) begin
      rej = cvi;
      start = 1;
    end else if (svi) begin
      rej = cvi;
      if (mc >= price[si]) begin
        mc -= price[si];
        disp = 1;
        item = si;
        in_vend = 1;
      end else den = 1;
    end else if (cvi) begin
      v = ct == 0 ? 5 : ct == 1 ? 10 : ct == 2 ? 25 : 0;
      if (v == 0 || mc + v > 100) rej = 1;
      else mc += v;
    end
    if (start) begin
      c = mc;
      while (c >= 25) begin q.push_back(25); c -= 25; end
      while (c >= 10) begin q.push_back(10); c -= 10; end
      while (c >= 5) begin q.push_back(5); c -= 5; end
      q.push_back(0);
    end
    if (!in_vend && q.size() > 0) begin
      v = q.pop_front();
      chg = v > 0;
      mc -= v;
      cc = v == 25 ? 2'd2 : v == 10 ? 2'd1 : 2'd0;
    end
    busy = in_vend || q.size() > 0;
    exp = {8'(mc), rej, den, disp, item, chg, cc, busy};
    @(posedge clk);
    #1;
    {vif.coin_valid, vif.coin_type, vif.sel_valid, vif.sel_item, vif.cancel} = NOP;
  endtask
  task automatic test_reset;
    {vif.coin_valid, vif.coin_type, vif.sel_valid, vif.sel_item, vif.cancel} = NOP;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 17'd0) begin n_fail++; $display("FAIL reset got %h expected %h", obs, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(NOP);
    n_chk++;
    if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_release got %h expected %h", obs, 17'd0); end
  endtask
  task automatic test_purchase;
    logic [6:0] s[$] = '{C25, C10, sel(2'd1), NOP};
    logic [16:0] h[$];
    logic [21:0] got, want;
    foreach (s[i]) begin
      cyc(s[i]);
      h.push_back(obs);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL purchase step %0d got %h expected %h", i, obs, exp); end
    end
    got = {h[0][16:9], h[1][16:9], h[2][6], h[2][5:4], h[3][3], h[3][0]};
    want = {8'd25, 8'd35, 1'b1, 2'd1, 1'b0, 1'b0};
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL purchase_values got %h expected %h", got, want); end
  endtask
  task automatic test_vend_change;
    logic [6:0] s[$] = '{C25, C25, sel(2'd0), NOP, NOP};
    logic [22:0] got, want;
    logic [16:0] h[$];
    foreach (s[i]) begin
      cyc(s[i]);
      h.push_back(obs);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL vend_change step %0d got %h expected %h", i, obs, exp); end
    end
    got = {h[2][6], h[2][16:9], h[3][3], h[3][2:1], h[3][16:9], h[4][3], h[4][0]};
    want = {1'b1, 8'd25, 1'b1, 2'd2, 8'd0, 1'b0, 1'b0};
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL vend_change_values got %h expected %h", got, want); end
  endtask
  task automatic test_cancel;
    logic [6:0] s[$] = '{C25, C10, C5, CAN, NOP, NOP, NOP};
    logic [16:0] h[$];
    logic [20:0] got, want;
    foreach (s[i]) begin
      cyc(s[i]);
      h.push_back(obs);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL cancel step %0d got %h expected %h", i, obs, exp); end
    end
    got = {h[3][3], h[3][2:1], h[4][3], h[4][2:1], h[5][3], h[5][2:1],
           h[3][0], h[4][0], h[5][0], h[6][0], h[6][3], h[6][16:9]};
    want = {1'b1, 2'd2, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL cancel_values got %h expected %h", got, want); end
  endtask
  task automatic test_denied;
    logic [6:0] s[$] = '{C10, sel(2'd2), CBAD, NOP, CAN, NOP};
    logic [16:0] h[$];
    logic [19:0] got, want;
    foreach (s[i]) begin
      cyc(s[i]);
      h.push_back(obs);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL denied step %0d got %h expected %h", i, obs, exp); end
    end
    got = {h[1][7], h[1][16:9], h[2][8], h[2][16:9], h[3][7], h[3][8]};
    want = {1'b1, 8'd10, 1'b1, 8'd10, 1'b0, 1'b0};
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL denied_values got %h expected %h", got, want); end
  endtask
  task automatic test_ceiling;
    logic [6:0] s[$] = '{C25, C25, C25, C25, C5, C10 | sel(2'd3), NOP, NOP, NOP};
    logic [16:0] h[$];
    logic [26:0] got, want;
    foreach (s[i]) begin
      cyc(s[i]);
      h.push_back(obs);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL ceiling step %0d got %h expected %h", i, obs, exp); end
    end
    got = {h[4][8], h[4][16:9], h[5][6], h[5][5:4], h[5][8], h[5][16:9], h[6][2:1], h[7][2:1], h[8][0]};
    want = {1'b1, 8'd100, 1'b1, 2'd3, 1'b1, 8'd35, 2'd2, 2'd1, 1'b0};
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL ceiling_values got %h expected %h", got, want); end
  endtask
  task automatic test_reset_mid_change;
    logic [6:0] s[$] = '{C25, C25, C10, CAN};
    foreach (s[i]) begin
      cyc(s[i]);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL mid_change step %0d got %h expected %h", i, obs, exp); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 17'd0) begin n_fail++; $display("FAIL mid_change_async got %h expected %h", obs, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    s = '{NOP, C5, CAN, NOP};
    foreach (s[i]) begin
      cyc(s[i]);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL after_reset step %0d got %h expected %h", i, obs, exp); end
    end
  endtask
  task automatic test_random;
    logic [6:0] s;
    for (int i = 0; i < 600; i++) begin
      s = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0)};
      cyc(s);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL random cycle %0d stim %b got %h expected %h", i, s, obs, exp); end
    end
  endtask
  initial begin
    test_reset();
    test_purchase();
    test_vend_change();
    test_cancel();
    test_denied();
    test_ceiling();
    test_reset_mid_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Central sequencing FSM for the vending machine. It accumulates coin credit, checks item selections against per-item prices, pulses the dispense mechanism, and returns change one coin per cycle. It sits between the coin/keypad input registers and the dispense/change actuators. All outputs are registered.

Parameters:
PRICE0, 25, price of item 0 in cents; must be a multiple of 5
PRICE1, 35, price of item 1 in cents; must be a multiple of 5
PRICE2, 50, price of item 2 in cents; must be a multiple of 5
PRICE3, 65, price of item 3 in cents; must be a multiple of 5
MAX_CREDIT, 100, credit ceiling in cents; must be a multiple of 5
CREDIT_W, 8, width of the credit register; must hold MAX_CREDIT+25

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_valid  in  1  one-cycle strobe; a coin is presented
coin_type  in  2  0=5c, 1=10c, 2=25c, 3=invalid/slug
sel_valid  in  1  one-cycle strobe; an item is selected
sel_item  in  2  item index 0..3
cancel  in  1  one-cycle strobe; refund all credit
credit  out  CREDIT_W  current credit in cents
coin_reject  out  1  one-cycle pulse; presented coin returned unaccepted
sel_denied  out  1  one-cycle pulse; credit below price
dispense  out  1  one-cycle pulse; release item
dispense_item  out  2  item index, valid while dispense=1
change_valid  out  1  one change coin is ejected this cycle
change_coin  out  2  coin type of the change coin (0/1/2)
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, credit=0, all pulse outputs=0, dispense_item=0, change_coin=0, busy=0.
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- Input priority in IDLE/CREDIT within one cycle: cancel > sel_valid > coin_valid. A coin that is not processed because of a higher-priority event gets coin_reject=1 in the next cycle.
- Coin, cycle N: coin_type=3 -> coin_reject at N+1, credit unchanged. Valid coin with credit+value <= MAX_CREDIT -> credit=credit+value visible at N+1, state=CREDIT. Valid coin that would exceed MAX_CREDIT -> coin_reject at N+1, credit unchanged.
- Select, cycle N: credit >= PRICE[sel_item] -> VEND at N+1 with dispense=1, dispense_item=sel_item, and credit reduced by the price in the same cycle. If credit < price -> sel_denied=1 at N+1, state and credit unchanged. Select in IDLE -> sel_denied.
- VEND lasts exactly 1 cycle. Next state is CHANGE if the remaining credit > 0, otherwise IDLE.
- Cancel in CREDIT -> CHANGE. Cancel in IDLE is ignored.
- CHANGE: one coin per cycle, greedy largest coin <= credit (25, then 10, then 5). change_valid=1, change_coin=type, and credit decrements by that value in the same cycle. Go to IDLE on the cycle after credit reaches 0. Example: 40c -> 25, 10, 5 over 3 cycles.
- In VEND/CHANGE: coin_valid -> coin_reject next cycle. sel_valid and cancel are ignored, with no sel_denied.
- Reset mid-CHANGE aborts: credit is lost and state goes to IDLE. This is intentional; no residual pulses.
- Pulse outputs (coin_reject, sel_denied, dispense, change_valid) are never high for more than one cycle per event, except change_valid, which stays high for consecutive change cycles.
- Credit arithmetic is unsigned CREDIT_W bits. It cannot underflow or overflow, because of the price check and MAX_CREDIT.

Decomposition:
- Package vend_pkg holds:
  - coin type encodings COIN_5/COIN_10/COIN_25/COIN_BAD
  - coin value constants 5/10/25
  - state enum IDLE/CREDIT/VEND/CHANGE
  - function coin_value(type)
- Sub-module vend_change_sel: combinational greedy selector. Input is the remaining credit; outputs are the coin type and its value.
- Price lookup is a local mux over PRICE0..3 in vend_ctrl.

Test Plan:
- Reset then insert 25,10 -> credit=25 then 35. Select item1 (35) -> dispense=1, dispense_item=1, credit=0, IDLE with no change_valid.
- Credit 50 (25+25), select item0 (25) -> dispense, then one change cycle of change_coin=25, then IDLE, credit=0.
- Credit 40 (25+10+5), cancel -> change_valid for 3 consecutive cycles with coins 25, 10, 5; busy high throughout; IDLE after.
- Credit 10, select item2 (50) -> sel_denied pulse, credit stays 10. Insert coin_type=3 -> coin_reject pulse, credit stays 10.
- Credit 100 (4x25), insert 5 -> coin_reject, credit=100. Same-cycle sel_valid(item3) + coin_valid(10) -> dispense item3, coin_reject next cycle, change 35 = 25,10.
- Credit 60 mid-CHANGE, assert rst_n=0 asynchronously between edges -> outputs zero immediately, state IDLE, credit=0 after release.
